// File: rtl/fft_reorder_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder_buf_if
// Description : Stream bundle around the FFT output reorder buffer.
//               Input side : in_valid/in_ready/in_sof/in_re/in_im (bit-reversed)
//               Output side: out_valid/out_ready/out_re/out_im/out_index/out_last
//               modport slave  - the reorder buffer itself
//               modport master - the environment (upstream FFT + downstream sink)
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_reorder_buf_if #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 10
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sof;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic [LOG2N-1:0]         out_index;
  logic                     out_last;

  modport slave (
    input  in_valid, in_sof, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_index, out_last
  );

  modport master (
    output in_valid, in_sof, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_index, out_last
  );
endinterface
`default_nettype wire

// File: rtl/fft_reorder_buf.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder_buf
// Description : Ping-pong reorder buffer for a radix-2 SDF FFT. Samples arrive
//               in bit-reversed order and are replayed X[0]..X[N-1] on a
//               valid/ready stream. One bank fills while the other drains.
// Ports       : clk, rst_n (async, active low)
//               bus : fft_reorder_buf_if.slave (input and output streams)
//               sync_err, drop_cnt : only with REORDER_STATUS_EN defined
// Config      : `define REORDER_STATUS_EN adds the resync status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder_buf #(
  parameter int FFT_N  = 1024,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_reorder_buf_if.slave bus
`ifdef REORDER_STATUS_EN
  ,
  output logic             sync_err,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int               LOG2N      = $clog2(FFT_N);
  localparam logic [LOG2N-1:0] c_last_idx = LOG2N'(FFT_N - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_read  = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [LOG2N-1:0]         wr_cnt_q,    wr_cnt_d;
  logic                     wr_bank_q,   wr_bank_d;
  logic [1:0]               full_q,      full_d;
  logic [LOG2N-1:0]         rd_cnt_q,    rd_cnt_d;
  logic                     rd_bank_q,   rd_bank_d;
  logic [1:0]               state_q,     state_d;
  logic                     rd_pend_q,   rd_pend_d;
  logic [LOG2N-1:0]         rd_idx_q,    rd_idx_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q,  out_last_d;
  logic signed [DATA_W-1:0] out_re_q,    out_re_d;
  logic signed [DATA_W-1:0] out_im_q,    out_im_d;
  logic [LOG2N-1:0]         out_index_q, out_index_d;

  logic                     wr_en;
  logic [LOG2N-1:0]         wr_idx;
  logic                     resync;
  logic [1:0]               full_set;
  logic [1:0]               full_clr;
  logic                     adv;
  logic                     issue;

  // Storage: both banks in one array, bank select is the address MSB.
  logic [2*DATA_W-1:0]      mem [0:2*FFT_N-1];
  // Registered RAM read port; only consumed when rd_pend_q marks it valid.
  logic [2*DATA_W-1:0]      ram_rd_data;

  // --------------------------------------------------------------------------
  // Write side
  // --------------------------------------------------------------------------
  assign bus.in_ready = ~full_q[wr_bank_q];
  assign wr_en        = bus.in_valid & ~full_q[wr_bank_q];

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    wr_idx    = bitrev(wr_cnt_q);
    resync    = 1'b0;
    full_set  = 2'b00;
    if (wr_en) begin
      if (bus.in_sof && (wr_cnt_q != '0)) begin
        // Restart the current bank: the partial frame is overwritten.
        resync   = 1'b1;
        wr_idx   = '0;
        wr_cnt_d = LOG2N'(1);
      end else if (wr_cnt_q == c_last_idx) begin
        full_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
        wr_cnt_d            = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + LOG2N'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read side
  // --------------------------------------------------------------------------
  // The two-stage read pipeline (RAM register, output register) moves as a
  // unit whenever the output register is empty or being accepted.
  assign adv   = ~out_valid_q | bus.out_ready;
  // IDLE and DRAIN start the next frame on the same cycle its bank is seen
  // full, which keeps back-to-back frames free of bubbles.
  assign issue = adv & ((state_q == c_st_read) | full_q[rd_bank_q]);

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    full_clr  = 2'b00;
    if (issue) begin
      if (rd_cnt_q == c_last_idx) begin
        full_clr[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
        rd_cnt_d            = '0;
        state_d             = c_st_drain;
      end else begin
        rd_cnt_d = rd_cnt_q + LOG2N'(1);
        state_d  = c_st_read;
      end
    end else if ((state_q == c_st_drain) && out_valid_q && bus.out_ready && out_last_q) begin
      state_d = c_st_idle;
    end
  end

  // Clear is applied after set so a release wins on a shared edge.
  assign full_d = (full_q | full_set) & ~full_clr;

  always_comb begin
    rd_pend_d   = rd_pend_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_index_d = out_index_q;
    if (adv) begin
      rd_pend_d   = issue;
      rd_idx_d    = issue ? rd_cnt_q : rd_idx_q;
      out_valid_d = rd_pend_q;
      out_last_d  = rd_pend_q && (rd_idx_q == c_last_idx);
      if (rd_pend_q) begin
        out_re_d    = ram_rd_data[2*DATA_W-1:DATA_W];
        out_im_d    = ram_rd_data[DATA_W-1:0];
        out_index_d = rd_idx_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_index = out_index_q;

  // --------------------------------------------------------------------------
  // RAM (contents are never reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank_q, wr_idx}] <= {bus.in_re, bus.in_im};
    if (issue) ram_rd_data <= mem[{rd_bank_q, rd_cnt_q}];
  end

  // --------------------------------------------------------------------------
  // Control / output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      state_q     <= c_st_idle;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_index_q <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_index_q <= out_index_d;
    end
  end

`ifdef REORDER_STATUS_EN
  // --------------------------------------------------------------------------
  // Resync status
  // --------------------------------------------------------------------------
  logic        sync_err_q, sync_err_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    sync_err_d = sync_err_q | resync;
    drop_cnt_d = drop_cnt_q;
    if (resync && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      sync_err_q <= sync_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign sync_err = sync_err_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire
